// File: rtl/riscv_pkg.sv
// Shared register-file parameters and debug-master FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_REG_COUNT  = 32;

    // Debug master states. IDLE passes the core through to the register file.
    // Every other state owns the register-file ports and stalls the core.
    typedef enum logic [2:0] {
        DBG_IDLE  = 3'd0,
        DBG_READ  = 3'd1,
        DBG_WRITE = 3'd2,
        DBG_CLEAR = 3'd3,
        DBG_RESP  = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/regfile_debug_master.sv
// Debug port that steals the register-file ports from the core for read, write and clear-all commands.
// Latency: read/write respond 2 edges after accept; clear responds REG_COUNT edges after accept.
// Backpressure: one request in flight; req_ready low from accept until the response is taken with rsp_ready.
module regfile_debug_master
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_COUNT  = RF_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_clear,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    input  logic                  core_we3,
    input  logic [ADDR_WIDTH-1:0] core_a3,
    input  logic [DATA_WIDTH-1:0] core_wd3,
    input  logic [ADDR_WIDTH-1:0] core_a1,
    output logic [DATA_WIDTH-1:0] core_rd1,
    output logic                  core_halt,

    output logic                  rf_we3,
    output logic [ADDR_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd3,
    output logic [ADDR_WIDTH-1:0] rf_a1,
    input  logic [DATA_WIDTH-1:0] rf_rd1
);

    localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(REG_COUNT - 1);

    dbg_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  core_halt_q, core_halt_d;

    // An address beyond the implemented registers must never be written;
    // such a write is serviced as a read so the caller sees what the file returns.
    logic [31:0] req_addr_ext;
    logic        req_addr_oob;
    assign req_addr_ext = 32'(req_addr);
    assign req_addr_oob = (req_addr_ext >= 32'(REG_COUNT));

    // Next-state logic: accept in IDLE, execute for one cycle (or sweep for clear), then hold the response.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            DBG_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_clear) begin
                        state_d = DBG_CLEAR;
                        cnt_d   = CNT_FIRST;
                    end else if (req_write && !req_addr_oob) begin
                        state_d = DBG_WRITE;
                    end else begin
                        state_d = DBG_READ;
                    end
                end
            end
            DBG_READ: begin
                rsp_rdata_d = rf_rd1;
                state_d     = DBG_RESP;
            end
            DBG_WRITE: begin
                rsp_rdata_d = wdata_q;
                state_d     = DBG_RESP;
            end
            DBG_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = CNT_FIRST;
                    rsp_rdata_d = '0;
                    state_d     = DBG_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            DBG_RESP: begin
                if (rsp_ready) begin
                    state_d = DBG_IDLE;
                end
            end
            default: begin
                state_d = DBG_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == DBG_RESP);
        core_halt_d = (state_d != DBG_IDLE);
    end

    // State and registered outputs; reset abandons any sweep in progress without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DBG_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= CNT_FIRST;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            core_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            core_halt_q <= core_halt_d;
        end
    end

    // Register-file port mux: core owns the ports in IDLE, the FSM owns them otherwise.
    always_comb begin
        rf_we3 = 1'b0;
        rf_a3  = core_a3;
        rf_wd3 = core_wd3;
        rf_a1  = core_a1;
        case (state_q)
            DBG_IDLE: begin
                rf_we3 = core_we3;
            end
            DBG_READ: begin
                rf_a1 = addr_q;
            end
            DBG_WRITE: begin
                rf_a3  = addr_q;
                rf_wd3 = wdata_q;
                rf_we3 = (addr_q != '0);
            end
            DBG_CLEAR: begin
                rf_a3  = cnt_q;
                rf_wd3 = '0;
                rf_we3 = 1'b1;
            end
            default: begin
                rf_we3 = 1'b0;
            end
        endcase
        // Reset must suppress every write, including a pending sweep step.
        if (rst) begin
            rf_we3 = 1'b0;
        end
    end

    assign req_ready = (state_q == DBG_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign core_halt = core_halt_q;
    assign core_rd1  = rf_rd1;

endmodule

// File: tb/tb_regfile_debug_master.sv
module tb_regfile_debug_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_clear;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        core_we3;
    logic [4:0]  core_a3, core_a1;
    logic [31:0] core_wd3, core_rd1;
    logic        core_halt;
    logic        rf_we3;
    logic [4:0]  rf_a3, rf_a1;
    logic [31:0] rf_wd3, rf_rd1;

    int checks = 0;
    int errors = 0;
    int halt_cnt = 0;
    int we_cnt = 0;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    regfile_debug_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_clear (req_clear),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .core_we3  (core_we3),
        .core_a3   (core_a3),
        .core_wd3  (core_wd3),
        .core_a1   (core_a1),
        .core_rd1  (core_rd1),
        .core_halt (core_halt),
        .rf_we3    (rf_we3),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .rf_a1     (rf_a1),
        .rf_rd1    (rf_rd1)
    );

    // Behavioural register file attached to the rf_* side.
    always @(posedge clk) begin
        if (rf_we3 && rf_a3 != 5'd0) regs[rf_a3] <= rf_wd3;
    end
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : regs[rf_a1];

    always @(posedge clk) begin
        if (core_halt) halt_cnt <= halt_cnt + 1;
        if (rf_we3) we_cnt <= we_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic w, input logic c, input logic [4:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_clear = c; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_clear = 1'b0;
    endtask

    task automatic wait_rsp(output logic ok, output int edges);
        ok = 1'b0;
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            edges++;
        end
    endtask

    task automatic dbg_read(input logic [4:0] a, output logic [31:0] d, output logic ok);
        int e;
        send_req(1'b0, 1'b0, a, 32'd0);
        wait_rsp(ok, e);
        d = rsp_rdata;
        step();
    endtask

    task automatic core_preload(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            core_we3 = 1'b1; core_a3 = 5'(i); core_wd3 = base + 32'(i);
            step();
        end
        core_we3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_we3 = 1'b1; core_a3 = 5'd3; core_wd3 = 32'h1111_1111; core_a1 = 5'd0;
        step(); step();
        checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b expected 0", rf_we3); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (core_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", core_halt); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        core_we3 = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_passthrough();
        core_we3 = 1'b1; core_a3 = 5'd12; core_wd3 = 32'h0BAD_F00D; core_a1 = 5'd9;
        #1;
        checks++; if ({rf_we3, rf_a3, rf_wd3, rf_a1} !== {1'b1, 5'd12, 32'h0BAD_F00D, 5'd9}) begin
            errors++; $display("FAIL idle_mux: got we=%b a3=%0d wd=%h a1=%0d expected we=1 a3=12 wd=0badf00d a1=9", rf_we3, rf_a3, rf_wd3, rf_a1);
        end
        step();
        core_we3 = 1'b0; core_a1 = 5'd12;
        #1;
        checks++; if (core_rd1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL idle_rd1: got %h expected 0badf00d", core_rd1); end
    endtask

    task automatic test_read();
        logic ok;
        int e, h0;
        h0 = halt_cnt;
        core_we3 = 1'b1; core_a3 = 5'd5; core_wd3 = 32'hDEAD_BEEF;
        send_req(1'b0, 1'b0, 5'd5, 32'd0);
        core_we3 = 1'b0;
        checks++; if (rf_a1 !== 5'd5 || core_halt !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL read_exec: got a1=%0d halt=%b rdy=%b expected a1=5 halt=1 rdy=0", rf_a1, core_halt, req_ready);
        end
        wait_rsp(ok, e);
        checks++; if (!ok || e + 1 !== 2) begin errors++; $display("FAIL read_latency: got %0d edges ok=%b expected 2", e + 1, ok); end
        checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rsp_rdata); end
        step();
        checks++; if (halt_cnt - h0 !== 2) begin errors++; $display("FAIL read_halt_cycles: got %0d expected 2", halt_cnt - h0); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL read_idle: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_block();
        logic ok;
        logic [31:0] d;
        core_we3 = 1'b1; core_a3 = 5'd7; core_wd3 = 32'h5555; core_a1 = 5'd9;
        send_req(1'b1, 1'b0, 5'd7, 32'h1234);
        checks++; if ({rf_we3, rf_a3, rf_wd3, rf_a1} !== {1'b1, 5'd7, 32'h1234, 5'd9}) begin
            errors++; $display("FAIL write_exec: got we=%b a3=%0d wd=%h a1=%0d expected we=1 a3=7 wd=1234 a1=9", rf_we3, rf_a3, rf_wd3, rf_a1);
        end
        step();
        checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL write_resp_we3: got %b expected 0", rf_we3); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234) begin errors++; $display("FAIL write_rsp: got vld=%b data=%h expected 1 1234", rsp_valid, rsp_rdata); end
        core_we3 = 1'b0;
        step();
        dbg_read(5'd7, d, ok);
        checks++; if (!ok || d !== 32'h1234) begin errors++; $display("FAIL write_final_x7: got %h ok=%b expected 1234", d, ok); end
    endtask

    task automatic test_write_x0();
        logic ok;
        logic [31:0] d;
        int e;
        send_req(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL x0_we3: got %b expected 0", rf_we3); end
        wait_rsp(ok, e);
        checks++; if (!ok || rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL x0_echo: got %h ok=%b expected ffffffff", rsp_rdata, ok); end
        step();
        dbg_read(5'd0, d, ok);
        checks++; if (!ok || d !== 32'd0) begin errors++; $display("FAIL x0_read: got %h ok=%b expected 0", d, ok); end
    endtask

    task automatic test_clear();
        logic ok;
        logic [31:0] d;
        int e, w0;
        core_preload(32'd0);
        dbg_read(5'd31, d, ok);
        checks++; if (!ok || d !== 32'd31) begin errors++; $display("FAIL clear_preload: got %h ok=%b expected 1f", d, ok); end
        w0 = we_cnt;
        send_req(1'b1, 1'b1, 5'd3, 32'hAAAA);
        wait_rsp(ok, e);
        checks++; if (!ok || e + 1 !== 32) begin errors++; $display("FAIL clear_latency: got %0d edges ok=%b expected 32", e + 1, ok); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL clear_rdata: got %h expected 0", rsp_rdata); end
        step();
        checks++; if (we_cnt - w0 !== 31) begin errors++; $display("FAIL clear_we_cycles: got %0d expected 31", we_cnt - w0); end
        for (int i = 1; i < 32; i++) begin
            dbg_read(5'(i), d, ok);
            checks++; if (!ok || d !== 32'd0) begin errors++; $display("FAIL clear_x%0d: got %h ok=%b expected 0", i, d, ok); end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int e;
        rsp_ready = 1'b0;
        send_req(1'b1, 1'b0, 5'd3, 32'h77);
        wait_rsp(ok, e);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got none expected rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got vld=%b data=%h rdy=%b expected 1 77 0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_clear();
        logic ok;
        logic [31:0] d, exp;
        core_preload(32'h100);
        send_req(1'b0, 1'b1, 5'd0, 32'd0);
        for (int i = 0; i < 9; i++) step();
        checks++; if (rf_a3 !== 5'd10 || rf_we3 !== 1'b1) begin errors++; $display("FAIL midclr_cnt: got a3=%0d we=%b expected 10 1", rf_a3, rf_we3); end
        rst = 1'b1;
        #1;
        checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL midclr_rst_we3: got %b expected 0", rf_we3); end
        step();
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || core_halt !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midclr_idle: got vld=%b halt=%b rdy=%b expected 0 0 1", rsp_valid, core_halt, req_ready);
        end
        for (int i = 1; i < 32; i++) begin
            exp = (i < 10) ? 32'd0 : 32'h100 + 32'(i);
            dbg_read(5'(i), d, ok);
            checks++; if (!ok || d !== exp) begin errors++; $display("FAIL midclr_x%0d: got %h ok=%b expected %h", i, d, ok, exp); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_clear = 1'b0; req_addr = 5'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        core_we3 = 1'b0; core_a3 = 5'd0; core_wd3 = 32'd0; core_a1 = 5'd0;
        test_reset();
        test_idle_passthrough();
        test_read();
        test_write_block();
        test_write_x0();
        test_clear();
        test_backpressure();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_debug_master.md
REGFILE_DEBUG_MASTER -- requirements
Module: regfile_debug_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of registers; x0 is hardwired zero.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have debug request ports: req_valid in 1 request present; req_ready out 1 request accepted; req_write in 1 write (else read); req_clear in 1 clear-all command; req_addr in ADDR_WIDTH target register; req_wdata in DATA_WIDTH write data.
REQ-006 SHALL have debug response ports: rsp_valid out 1 response present; rsp_ready in 1 response consumed; rsp_rdata out DATA_WIDTH read data, or echoed write data.
REQ-007 SHALL have core-side ports: core_we3 in 1; core_a3 in ADDR_WIDTH; core_wd3 in DATA_WIDTH; core_a1 in ADDR_WIDTH; core_rd1 out DATA_WIDTH; core_halt out 1 core stall request.
REQ-008 SHALL have register-file-side ports: rf_we3 out 1; rf_a3 out ADDR_WIDTH; rf_wd3 out DATA_WIDTH; rf_a1 out ADDR_WIDTH; rf_rd1 in DATA_WIDTH, combinational read data.

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, CLEAR, RESP.
REQ-010 In IDLE: req_ready=1, core_halt=0; rf_we3/rf_a3/rf_wd3/rf_a1 SHALL equal the core_* inputs.
REQ-011 On a req_valid&&req_ready edge, the FSM SHALL latch addr/wdata and go to CLEAR if req_clear=1 (clear wins over write), else WRITE if req_write=1, else READ.
REQ-012 In every non-IDLE state: req_ready=0, core_halt=1, core write port ignored; rf_we3=0 unless the state specifies otherwise.
REQ-013 READ SHALL last one cycle with rf_a1=latched addr, capture rf_rd1 into rsp_rdata at the edge, and go to RESP.
REQ-014 WRITE SHALL last one cycle with rf_a3=addr, rf_wd3=wdata, rf_we3=1 (0 when addr=0), set rsp_rdata=wdata, and go to RESP.
REQ-015 CLEAR SHALL sweep an internal counter from 1 to REG_COUNT-1, one register per cycle (rf_we3=1, rf_wd3=0, rf_a3=counter), i.e. REG_COUNT-1 cycles, then go to RESP with rsp_rdata=0.
REQ-016 RESP SHALL hold rsp_valid=1 and rsp_rdata stable until rsp_ready=1 is sampled; it SHALL then go to IDLE, where rsp_valid=0.
REQ-017 core_rd1 SHALL always equal rf_rd1; rf_a1 SHALL equal core_a1 outside READ.
REQ-018 Request-to-response latency: 2 edges for read/write (accept, execute); REG_COUNT edges for clear.
REQ-019 A core write coincident with request acceptance in IDLE SHALL complete; a debug read of the same register SHALL observe it.
REQ-020 req_addr >= REG_COUNT SHALL be accepted and answered: no write, rsp_rdata = rf_rd1 as returned.

Reset
REQ-021 On rst at a rising edge: state=IDLE, counter=1, rsp_valid=0, rsp_rdata=0, core_halt=0.
REQ-022 While rst=1, rf_we3 SHALL be 0 regardless of core_we3.
REQ-023 Reset mid-CLEAR SHALL abort the sweep with no response; already-cleared registers stay cleared.

Structure
REQ-024 DATA_WIDTH/ADDR_WIDTH/REG_COUNT defaults and the FSM state encoding SHALL reside in a shared riscv_pkg package.
REQ-025 The block SHALL be a single module with no sub-module; the port mux is combinational off the state register.

Verification
REQ-026 Core write x5=0xDEAD_BEEF; debug read addr 5 -> rsp_rdata=0xDEAD_BEEF, rsp_valid 2 edges after accept, core_halt high 2 cycles.
REQ-027 Debug write addr 7 data 0x1234 while core_we3=1 to x7 data 0x5555 -> core write blocked in WRITE; final x7=0x1234; rsp_rdata=0x1234.
REQ-028 Debug write addr 0 data 0xFFFF_FFFF -> rf_we3 stays 0; read addr 0 returns 0.
REQ-029 Preload x1..x31=i; clear (req_clear=1, req_write=1) -> rsp after 32 edges; all reads return 0; rf_we3 high exactly 31 cycles.
REQ-030 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; the cycle after rsp_ready=1, req_ready=1.
REQ-031 Assert rst at counter=10 in CLEAR -> next cycle IDLE, rsp_valid=0; x1..x9 read 0, x10..x31 keep preload values.
